// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: fixed-priority arbitration over NSRC level
// sources, a single REQ/SERV handshake with the CPU, and EOI-based completion.
module int_ctrl #(
    parameter int                 ABITS = 32,
    parameter int                 DBITS = 32,
    parameter logic [ABITS-1:0]   IBASE = 32'hF0000100,
    parameter int                 NSRC  = 4,
    parameter int                 IDB   = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              LOCK,
    input  logic [ABITS-1:0]  ABUS,
    input  logic [DBITS-1:0]  WBUS,
    inout  wire  [DBITS-1:0]  RBUS,
    input  logic              RE,
    input  logic              WE,
    input  logic [NSRC-1:0]   IRQ,
    input  logic              IACK,
    output logic              INTR,
    output logic [IDB-1:0]    IVEC
);
    localparam logic [ABITS-1:0] A_MASK = IBASE;
    localparam logic [ABITS-1:0] A_PEND = IBASE + ABITS'(2);
    localparam logic [ABITS-1:0] A_CTRL = IBASE + ABITS'(4);
    localparam logic [ABITS-1:0] A_EOI  = IBASE + ABITS'(6);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_REQ = 2'b01, S_SERV = 2'b10} state_t;

    state_t            state, state_n;
    logic [NSRC-1:0]   mask, pend;
    logic              gie;
    logic [IDB-1:0]    win_id, ivec_n;
    logic              wr_mask, wr_ctrl, wr_eoi;
    logic              rd_hit;
    logic [DBITS-1:0]  rdata;
    logic              unused_wbus;

    assign pend        = IRQ & mask;
    assign wr_mask     = WE && (ABUS == A_MASK);
    assign wr_ctrl     = WE && (ABUS == A_CTRL);
    assign wr_eoi      = WE && (ABUS == A_EOI);
    assign unused_wbus = ^WBUS;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (pend[i]) win_id = IDB'(i);
    end

    always_comb begin
        state_n = state;
        ivec_n  = IVEC;
        case (state)
            S_IDLE: if (gie && (pend != '0)) begin
                state_n = S_REQ;
                ivec_n  = win_id;
            end
            S_REQ: begin
                if (IACK)                    state_n = S_SERV;
                else if (!pend[IVEC] || !gie) state_n = S_IDLE;
            end
            S_SERV: if (wr_eoi) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            mask  <= '0;
            gie   <= 1'b0;
            INTR  <= 1'b0;
            IVEC  <= '0;
        end else if (LOCK) begin
            state <= state_n;
            IVEC  <= ivec_n;
            INTR  <= (state_n == S_REQ);
            if (wr_mask) mask <= WBUS[NSRC-1:0];
            if (wr_ctrl) gie  <= WBUS[0];
        end
    end

    // EOI is write-only, so it is deliberately absent from the read decode.
    always_comb begin
        rdata  = '0;
        rd_hit = 1'b0;
        if (RE) begin
            case (ABUS)
                A_MASK: begin rd_hit = 1'b1; rdata[NSRC-1:0] = mask; end
                A_PEND: begin rd_hit = 1'b1; rdata[NSRC-1:0] = pend; end
                A_CTRL: begin
                    rd_hit        = 1'b1;
                    rdata[0]      = gie;
                    rdata[2:1]    = state;
                    rdata[8 +: IDB] = IVEC;
                end
                default: rd_hit = 1'b0;
            endcase
        end
    end

    assign RBUS = rd_hit ? rdata : {DBITS{1'bz}};
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: stimulus pushes expectations into a queue,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_int_ctrl;
    localparam logic [31:0] A_MASK = 32'hF0000100;
    localparam logic [31:0] A_PEND = 32'hF0000102;
    localparam logic [31:0] A_CTRL = 32'hF0000104;
    localparam logic [31:0] A_EOI  = 32'hF0000106;
    localparam logic [31:0] ZREAD  = 32'hFFFFFFFF;

    logic        CLK = 1'b0, RESET_N = 1'b0, LOCK = 1'b1;
    logic [31:0] ABUS = '0, WBUS = '0;
    logic        RE = 1'b0, WE = 1'b0, IACK = 1'b0;
    logic [3:0]  IRQ = '0;
    logic        INTR;
    logic [1:0]  IVEC;
    wire  [31:0] RBUS;

    // Undriven bus floats high, so a tri-stated read shows as all ones.
    pullup (RBUS);

    int_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOCK(LOCK), .ABUS(ABUS), .WBUS(WBUS),
        .RBUS(RBUS), .RE(RE), .WE(WE), .IRQ(IRQ), .IACK(IACK),
        .INTR(INTR), .IVEC(IVEC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;    // 0 INTR, 1 IVEC, 2 RBUS
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                0:       act = {31'b0, INTR};
                1:       act = {30'b0, IVEC};
                default: act = RBUS;
            endcase
            n_chk++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    end

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ABUS = a; WBUS = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        ABUS = a; RE = 1'b1;
        chk(2, exp, name);
        @(negedge CLK); #1;
        RE = 1'b0;
    endtask

    task automatic ack;
        IACK = 1'b1; tick(); IACK = 1'b0;
    endtask

    initial begin
        #12 RESET_N = 1'b1;
        tick();
        chk(0, 0, "reset_intr"); chk(1, 0, "reset_ivec");
        rd_chk(A_MASK, 32'h0, "reset_mask");
        rd_chk(A_CTRL, 32'h0, "reset_ctrl");

        // Basic request / ack / EOI flow, priority among 1 and 2.
        IRQ = 4'b0110;
        wr(A_MASK, 32'hF);
        wr(A_CTRL, 32'h1);
        chk(0, 0, "gie_edge_intr_low");
        rd_chk(A_CTRL, 32'h001, "ctrl_gie_idle");
        tick();
        chk(0, 1, "req_intr"); chk(1, 1, "req_ivec");
        rd_chk(A_CTRL, 32'h103, "ctrl_req");
        ack();
        chk(0, 0, "serv_intr");
        rd_chk(A_CTRL, 32'h105, "ctrl_serv");
        rd_chk(A_PEND, 32'h6, "pend_0110");
        wr(A_EOI, 32'h0);
        chk(0, 0, "eoi_gap_intr");
        rd_chk(A_CTRL, 32'h101, "ctrl_after_eoi");
        tick();
        chk(0, 1, "rereq_intr"); chk(1, 1, "rereq_ivec");

        // Higher-priority arrival while in REQ keeps latched id.
        ack(); IRQ = 4'b0100; wr(A_EOI, 0); tick();
        chk(1, 2, "req_id2");
        IRQ = 4'b0101; tick();
        chk(1, 2, "id2_held"); chk(0, 1, "id2_intr_held");
        ack(); wr(A_EOI, 0); tick();
        chk(1, 0, "id0_after_eoi"); chk(0, 1, "id0_intr");

        // Withdrawal in REQ, then withdrawal coincident with IACK.
        ack(); IRQ = 4'b1000; wr(A_EOI, 0); tick();
        chk(1, 3, "req_id3");
        IRQ = 4'b0000; tick();
        chk(0, 0, "withdraw_intr");
        rd_chk(A_CTRL, 32'h301, "withdraw_idle");
        IRQ = 4'b1000; tick();
        chk(0, 1, "req_id3_again");
        IRQ = 4'b0000; ack();
        chk(0, 0, "ack_wins_intr");
        rd_chk(A_CTRL, 32'h305, "ack_wins_serv");

        // GIE clear and stray IACK do not leave SERV.
        IRQ = 4'b0001;
        wr(A_CTRL, 32'h0); tick();
        rd_chk(A_CTRL, 32'h304, "serv_gie0");
        ack();
        rd_chk(A_CTRL, 32'h304, "serv_iack_ign");
        wr(A_CTRL, 32'h1);
        wr(A_EOI, 0);
        chk(0, 0, "eoi_pend_gap");
        rd_chk(A_CTRL, 32'h301, "eoi_pend_idle");
        tick();
        chk(0, 1, "eoi_pend_req"); chk(1, 0, "eoi_pend_ivec");

        // LOCK=0 freezes everything.
        ack();
        LOCK = 1'b0; wr(A_EOI, 0); tick(); LOCK = 1'b1;
        rd_chk(A_CTRL, 32'h005, "lock_serv_frozen");
        wr(A_EOI, 0);
        LOCK = 1'b0; tick(); tick();
        chk(0, 0, "lock_idle_intr");
        rd_chk(A_CTRL, 32'h001, "lock_idle_frozen");
        LOCK = 1'b1; tick();
        chk(0, 1, "unlock_req");

        rd_chk(32'hF0000108, ZREAD, "rd_unmapped_z");
        rd_chk(A_EOI, ZREAD, "rd_eoi_z");

        // Masked sources invisible; EOI in IDLE ignored.
        ack(); IRQ = 4'b1110;
        wr(A_MASK, 32'h1);
        wr(A_EOI, 0); tick();
        chk(0, 0, "masked_intr");
        rd_chk(A_PEND, 32'h0, "masked_pend");
        wr(A_EOI, 0);
        rd_chk(A_CTRL, 32'h001, "eoi_idle_ign");

        // Async reset out of SERV.
        IRQ = 4'b0001; tick(); ack();
        rd_chk(A_CTRL, 32'h005, "pre_reset_serv");
        RESET_N = 1'b0; #1;
        chk(0, 0, "rst_async_intr");
        rd_chk(A_MASK, 32'h0, "rst_async_mask");
        rd_chk(A_CTRL, 32'h0, "rst_async_ctrl");
        RESET_N = 1'b1; tick();
        wr(A_MASK, 32'hF); wr(A_CTRL, 32'h1); tick();
        chk(0, 1, "post_reset_req"); chk(1, 0, "post_reset_ivec");

        @(negedge CLK); #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Param ABITS, 32, bus address width.
REQ-002 Param DBITS, 32, bus data width.
REQ-003 Param IBASE, 32'hF0000100, base address of register block.
REQ-004 Param NSRC, 4, number of interrupt sources (max 8).
REQ-005 Param IDB, 2, width of source id (ceil log2 NSRC).
REQ-006 Port CLK in 1: sole clock, posedge.
REQ-007 Port RESET_N in 1: asynchronous, active-low reset.
REQ-008 Port LOCK in 1: clock-valid; all state updates occur only when LOCK=1.
REQ-009 Port ABUS in ABITS: bus address.
REQ-010 Port WBUS in DBITS: write data.
REQ-011 Port RBUS inout DBITS: read data, tri-stated when not selected.
REQ-012 Port RE in 1 / WE in 1: read / write strobes.
REQ-013 Port IRQ in NSRC: level interrupt lines from devices (Timer, KeyDev, SwDev INTR).
REQ-014 Port IACK in 1: one-cycle CPU acknowledge.
REQ-015 Port INTR out 1: interrupt request to CPU.
REQ-016 Port IVEC out IDB: id of the requested/serviced source.

Function
REQ-017 Registers: MASK @IBASE+0 RW bits[NSRC-1:0]; PEND @IBASE+2 RO = IRQ&MASK; CTRL @IBASE+4; EOI @IBASE+6 write-only.
REQ-018 CTRL: bit0 GIE RW; bits[2:1] state RO (00 IDLE, 01 REQ, 10 SERV); bits[(8+IDB-1):8] current id RO; other bits read 0; writes to RO bits ignored.
REQ-019 Reads combinational: RBUS driven only when RE and ABUS equals a readable register address; else all-z; EOI reads yield z.
REQ-020 Register writes take effect at posedge CLK when WE, address match, LOCK=1.
REQ-021 Priority: lowest-index set bit of PEND wins.
REQ-022 IDLE: if GIE=1 and PEND!=0, latch winning id into IVEC, go REQ next edge; else stay.
REQ-023 REQ: INTR=1 (registered, asserts first cycle in REQ); IVEC holds latched id.
REQ-024 REQ, IACK=1: go SERV; INTR=0 from next cycle.
REQ-025 REQ, IACK=0 and PEND[id]=0 (source withdrawn or masked) or GIE=0: return IDLE, INTR=0; IACK takes precedence if simultaneous.
REQ-026 REQ: a higher-priority arrival does not change the latched id.
REQ-027 SERV: INTR=0; no new request regardless of PEND until EOI write; IVEC held.
REQ-028 EOI write (any data) in SERV: go IDLE; EOI write in IDLE/REQ ignored.
REQ-029 IACK outside REQ ignored.
REQ-030 Simultaneous EOI write and pending source: IDLE next edge, REQ the edge after (one-cycle IDLE gap mandatory).
REQ-031 Clearing GIE in SERV does not exit SERV; only EOI does.
REQ-032 LOCK=0: state, registers, INTR, IVEC frozen.

Reset
REQ-033 RESET_N=0 asynchronously: MASK=0, GIE=0, state IDLE, INTR=0, IVEC=0, current id=0.
REQ-034 Reset mid-REQ or mid-SERV aborts immediately to reset values; no EOI needed afterwards.

Verification
REQ-035 MASK=4'b1111, GIE=1, IRQ=4'b0110 -> INTR=1 two edges later, IVEC=1; IACK -> INTR=0, CTRL[2:1]=10; EOI -> IDLE, next request IVEC=1 again.
REQ-036 In REQ id=2, IRQ[0] rises -> IVEC stays 2; after IACK+EOI, IVEC=0 issued.
REQ-037 In REQ id=3, IRQ[3] drops with IACK=0 -> IDLE, INTR=0; same with IACK=1 same cycle -> SERV.
REQ-038 MASK=4'b0001, IRQ=4'b1110 -> PEND reads 0, INTR stays 0; EOI write in IDLE -> no effect.
REQ-039 RESET_N pulsed low in SERV -> INTR=0, MASK=0, CTRL reads 0 without clock edge.
REQ-040 RE at IBASE+8 -> RBUS all-z; LOCK=0 with pending IRQ -> state unchanged.
